// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_if
//  Purpose  : Operand/result handshake bundle for the bit-serial adder.
//             The slave modport is the adder side, the master modport is the
//             producer/consumer side.
//  Revision : 1.0 - initial release
// ============================================================================
interface serial_adder_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Bit-serial WIDTH-bit adder, one bit per clock LSB first. The
//             one-bit full adder is two half-adder cells plus an OR; a carry
//             flip-flop closes the loop. Results leave via valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================

// Half-adder cell used as the building block of the serial full adder.
module half_adder (
  input  wire logic a_i,
  input  wire logic b_i,
  output      logic s_o,
  output      logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module serial_adder #(
  parameter int WIDTH = 16
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  serial_adder_if.slave     bus
);

  localparam int                 CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, sum_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               cout_q, ovf_q;

  logic               w_ha0_s, w_ha0_c, w_fa_s, w_ha1_c, w_fa_c;
  logic               w_last;

  // Full adder: first half adder combines the operand bits, the second folds
  // in the running carry; either stage generating a carry produces carry-out.
  half_adder u_ha0 (.a_i(a_q[0]),  .b_i(b_q[0]),  .s_o(w_ha0_s), .c_o(w_ha0_c));
  half_adder u_ha1 (.a_i(w_ha0_s), .b_i(carry_q), .s_o(w_fa_s),  .c_o(w_ha1_c));
  assign w_fa_c = w_ha0_c | w_ha1_c;

  assign w_last = (cnt_q == LAST);

  // State register; the asynchronous reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (w_last)        state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, then shift one bit through the full adder per
  // clock; sum bits enter at the MSB so the word is aligned after WIDTH shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            sum_q   <= '0;
            carry_q <= bus.cin;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          sum_q   <= {w_fa_s, sum_q[WIDTH-1:1]};
          a_q     <= {1'b0, a_q[WIDTH-1:1]};
          b_q     <= {1'b0, b_q[WIDTH-1:1]};
          carry_q <= w_fa_c;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (w_last) begin
            // carry_q is still the carry into the MSB at this point.
            ovf_q  <= carry_q ^ w_fa_c;
            cout_q <= w_fa_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Purpose  : Self-checking bench for serial_adder: directed corner cases,
//             backpressure, back-to-back, mid-run reset and random operands
//             against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition; overflow when equal-signed operands
  // give a result of the other sign.
  task automatic check_result(input string tag, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic c);
    logic [W:0] full;
    logic       exp_ovf;
    full    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    exp_ovf = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_sum"},   {16'd0, bus.sum},       {16'd0, full[W-1:0]});
    check({tag, "_cout"},  {31'd0, bus.cout},      {31'd0, full[W]});
    check({tag, "_ovf"},   {31'd0, bus.ovf},       {31'd0, exp_ovf});
  endtask

  // Present operands at a negedge and let the next posedge accept them.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    check("accept_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.a = a; bus.b = b; bus.cin = c;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
  endtask

  // Count edges from the accept edge until out_valid, with a bound.
  task automatic wait_done(output int n);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("idle_after_done", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic txn(input string tag, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic c);
    int lat;
    accept(a, b, c);
    wait_done(lat);
    check({tag, "_latency"}, lat, W);
    check_result(tag, a, b, c);
    release_out();
  endtask

  initial begin
    int            lat;
    logic [W-1:0]  ra, rb;
    logic          rc;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_sum",       {16'd0, bus.sum},       32'd0);
    check("rst_cout",      {31'd0, bus.cout},      32'd0);
    check("rst_ovf",       {31'd0, bus.ovf},       32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed corner cases
    txn("d_3p5",     16'h0003, 16'h0005, 1'b0);
    txn("d_ffff_p1", 16'hFFFF, 16'h0001, 1'b0);
    txn("d_7fff_p1", 16'h7FFF, 16'h0001, 1'b0);
    txn("d_8000x2",  16'h8000, 16'h8000, 1'b1);
    txn("d_1234",    16'h1234, 16'h4321, 1'b1);

    // Backpressure with a spurious in_valid pulse while DONE
    accept(16'hA5A5, 16'h5A5A, 1'b1);
    wait_done(lat);
    check("bp_latency", lat, W);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bus.in_valid = 1'b1;
        bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0;
      end
      if (i == 5) bus.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check_result("bp_hold", 16'hA5A5, 16'h5A5A, 1'b1);
    end
    release_out();

    // Back-to-back: in_valid and out_ready held high
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a = 16'h00FF; bus.b = 16'h0F0F; bus.cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.a = 16'hC000; bus.b = 16'hC000; bus.cin = 1'b1;
    wait_done(lat);
    check("b2b_lat1", lat, W);
    check_result("b2b_r1", 16'h00FF, 16'h0F0F, 1'b0);
    check("b2b_first_done_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("b2b_idle_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("b2b_second_accept", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    wait_done(lat);
    check("b2b_lat2", lat, W);
    check_result("b2b_r2", 16'hC000, 16'hC000, 1'b1);
    release_out();

    // Asynchronous reset during bit 7 of a run
    accept(16'hFFFF, 16'hFFFF, 1'b1);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn("post_rst_3p5", 16'h0003, 16'h0005, 1'b0);

    // Random operands with random consumer delay
    for (int k = 0; k < 24; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      accept(ra, rb, rc);
      wait_done(lat);
      check("rnd_latency", lat, W);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        @(negedge clk);
      end
      check_result("rnd", ra, rb, rc);
      release_out();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Bit-serial word adder for the datapath, built around the existing half-adder cell: two half-adder instances plus an OR form a one-bit full adder, and a carry flip-flop closes the loop. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. It then adds one bit per clock, LSB first, and presents the sum, carry-out and signed overflow on a valid/ready output port. It sits between the operand register file and the ALU result register, where area matters more than latency.

## Interface
- WIDTH, 16, operand and sum width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands and cin valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry into bit 0
- out_valid  output  1  sum, cout and ovf are valid
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1, out_valid=0. When in_valid=1 at a rising edge (accept):
  - load shift registers A←a and B←b
  - clear the sum shift register
  - carry←cin, bit counter←0
  - go to RUN
- RUN: in_ready=0, out_valid=0. Each edge:
  - full adder computes s = A[0]^B[0]^carry and c = majority(A[0],B[0],carry)
  - s shifts into the sum register MSB; A and B shift right by one
  - carry←c, counter increments
  - on the edge that processes bit WIDTH-1: latch ovf ← (carry before the edge) XOR c, set cout←c, go to DONE
- DONE: out_valid=1, and sum/cout/ovf hold stable. When out_ready=1 at an edge, go to IDLE. in_ready stays 0 for the whole state.
- in_valid is ignored outside IDLE. a, b and cin are sampled only on the accept edge and may change freely afterwards.
- Counter width is clog2(WIDTH) bits. It never wraps during a transaction because the terminal check is counter==WIDTH-1.
- Arithmetic is modular. Extra carry appears only on cout; no saturation.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, internal registers cleared. Release is sampled at the next clk edge.
- Latency: out_valid rises exactly WIDTH edges after the accept edge (WIDTH=16 → 16 cycles).
- Throughput: one result per WIDTH+2 cycles at best. The DONE→IDLE edge and the following accept edge are distinct, so in_ready is not asserted in the cycle the output handshake completes.
- Backpressure: out_ready low holds DONE indefinitely with outputs stable.
- out_ready high while not in DONE has no effect.
- Reset asserted mid-RUN or in DONE aborts the transaction immediately. No partial result is ever presented.
- sum, cout and ovf are don't-care while out_valid=0, but are driven from registers and hold their last values. The bench checks them only when out_valid=1.

## Test plan
- WIDTH=16, a=0x0003, b=0x0005, cin=0 -> out_valid 16 cycles after accept; sum=0x0008, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Separately, a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- a=0x8000, b=0x8000, cin=1 -> sum=0x0001, cout=1, ovf=1. Separately, a=0x1234, b=0x4321, cin=1 -> sum=0x5556.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0. While there, pulse in_valid with new operands -> ignored, and the result is unchanged after release.
- Back-to-back: in_valid held high with a new pair, out_ready=1 -> second accept occurs exactly 2 edges after the first DONE edge; both results correct.
- Reset: drop rst_n at bit 7 of a RUN -> in_ready=1 and out_valid=0 asynchronously. After release, a fresh 0x0003+0x0005 yields 0x0008 with no stale carry.
